// File: rtl/ps2_scan_decode_if.sv
// ps2_scan_decode_if
//   Bundles the byte-in strobe and the letter-out handshake of the PS/2
//   scan-code decoder.
//   scan_valid   : one-cycle strobe, scan_code holds a complete set-2 byte
//   scan_code    : received byte
//   letter_ready : consumer accepts letter this cycle when letter_valid=1
//   letter_valid : letter holds a decoded keypress
//   letter       : letter index 0 (A) .. 25 (Z)
//   overflow     : sticky, a decoded letter was dropped on a full buffer
//   master = byte source / letter consumer side, slave = decoder side.
interface ps2_scan_decode_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       letter_ready;
  logic       letter_valid;
  logic [4:0] letter;
  logic       overflow;

  modport master (
    output scan_valid, scan_code, letter_ready,
    input  letter_valid, letter, overflow
  );

  modport slave (
    input  scan_valid, scan_code, letter_ready,
    output letter_valid, letter, overflow
  );
endinterface

// File: rtl/ps2_scan_decode.sv
// ps2_scan_decode
//   Turns a stream of PS/2 set-2 scan bytes into letter indices A..Z.
//   Tracks F0/E0 prefixes, optionally drops typematic repeats of the held
//   key, and presents each letter through a one-entry valid/ready buffer.
//   Ports:
//     clk   : 50 MHz system clock, rising edge
//     rst_l : asynchronous active-low reset
//     bus   : ps2_scan_decode_if.slave (byte input, letter output, overflow)
//   Parameter SUPPRESS_REPEAT: 1 drops repeats of the held key, 0 emits all.
module ps2_scan_decode #(
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_l,
  ps2_scan_decode_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic [7:0] CODE_BRK = 8'hF0;
  localparam logic [7:0] CODE_EXT = 8'hE0;

  state_t     r_state;
  logic       r_held;
  logic [7:0] r_held_code;
  logic       r_letter_valid;
  logic [4:0] r_letter;
  logic       r_overflow;

  // Returns {hit, index}; hit=0 for any code that is not a letter key.
  function automatic logic [5:0] letter_map(input logic [7:0] code);
    logic [5:0] res;
    res = 6'd0;
    unique case (code)
      8'h1C: res = {1'b1, 5'd0};
      8'h32: res = {1'b1, 5'd1};
      8'h21: res = {1'b1, 5'd2};
      8'h23: res = {1'b1, 5'd3};
      8'h24: res = {1'b1, 5'd4};
      8'h2B: res = {1'b1, 5'd5};
      8'h34: res = {1'b1, 5'd6};
      8'h33: res = {1'b1, 5'd7};
      8'h43: res = {1'b1, 5'd8};
      8'h3B: res = {1'b1, 5'd9};
      8'h42: res = {1'b1, 5'd10};
      8'h4B: res = {1'b1, 5'd11};
      8'h3A: res = {1'b1, 5'd12};
      8'h31: res = {1'b1, 5'd13};
      8'h44: res = {1'b1, 5'd14};
      8'h4D: res = {1'b1, 5'd15};
      8'h15: res = {1'b1, 5'd16};
      8'h2D: res = {1'b1, 5'd17};
      8'h1B: res = {1'b1, 5'd18};
      8'h2C: res = {1'b1, 5'd19};
      8'h3C: res = {1'b1, 5'd20};
      8'h2A: res = {1'b1, 5'd21};
      8'h1D: res = {1'b1, 5'd22};
      8'h22: res = {1'b1, 5'd23};
      8'h35: res = {1'b1, 5'd24};
      8'h1A: res = {1'b1, 5'd25};
      default: res = 6'd0;
    endcase
    return res;
  endfunction

  logic [5:0] w_map;
  logic       w_make;
  logic       w_repeat;
  logic       w_emit;
  logic       w_break;
  logic       w_consume;

  always_comb begin
    w_map     = letter_map(bus.scan_code);
    // A byte in IDLE that is not a prefix is a make code.
    w_make    = bus.scan_valid && (r_state == IDLE) &&
                (bus.scan_code != CODE_BRK) && (bus.scan_code != CODE_EXT);
    w_repeat  = SUPPRESS_REPEAT && r_held && (bus.scan_code == r_held_code);
    w_emit    = w_make && w_map[5] && !w_repeat;
    w_break   = bus.scan_valid && (r_state == BRK);
    w_consume = r_letter_valid && bus.letter_ready;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state        <= IDLE;
      r_held         <= 1'b0;
      r_held_code    <= 8'h00;
      r_letter_valid <= 1'b0;
      r_letter       <= 5'd0;
      r_overflow     <= 1'b0;
    end else begin
      // Prefix tracking; only advances on a byte strobe.
      if (bus.scan_valid) begin
        unique case (r_state)
          IDLE: begin
            if (bus.scan_code == CODE_BRK)      r_state <= BRK;
            else if (bus.scan_code == CODE_EXT) r_state <= EXT;
            else                                r_state <= IDLE;
          end
          BRK:     r_state <= IDLE;
          EXT:     r_state <= (bus.scan_code == CODE_BRK) ? EXT_BRK : IDLE;
          EXT_BRK: r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end

      // Held-key tracking: an emitting make latches the key, its break
      // releases it. A break of some other key leaves the held key alone.
      if (w_emit) begin
        r_held      <= 1'b1;
        r_held_code <= bus.scan_code;
      end else if (w_break && (bus.scan_code == r_held_code)) begin
        r_held      <= 1'b0;
      end

      // One-entry output buffer. A slot freed this cycle can be refilled
      // in the same cycle, so back-to-back traffic never overflows.
      if (w_emit) begin
        if (!r_letter_valid || bus.letter_ready) begin
          r_letter_valid <= 1'b1;
          r_letter       <= w_map[4:0];
        end else begin
          r_overflow     <= 1'b1;
        end
      end else if (w_consume) begin
        r_letter_valid <= 1'b0;
      end
    end
  end

  assign bus.letter_valid = r_letter_valid;
  assign bus.letter       = r_letter;
  assign bus.overflow     = r_overflow;

endmodule

// File: tb/tb_ps2_scan_decode.sv
module tb_ps2_scan_decode;

  logic clk;
  logic rst_l;
  int   n_total;
  int   n_bad;
  int   acc_a;
  int   acc_b;
  int   base_a;
  int   base_b;

  ps2_scan_decode_if ifa ();
  ps2_scan_decode_if ifb ();

  ps2_scan_decode #(.SUPPRESS_REPEAT(1'b1)) dut_a (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (ifa.slave)
  );

  ps2_scan_decode #(.SUPPRESS_REPEAT(1'b0)) dut_b (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Accepted-letter counters (valid & ready at the active edge).
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      acc_a <= 0;
      acc_b <= 0;
    end else begin
      if (ifa.letter_valid && ifa.letter_ready) acc_a <= acc_a + 1;
      if (ifb.letter_valid && ifb.letter_ready) acc_b <= acc_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Strobe one byte into both decoders; returns on the following negedge,
  // one cycle after the strobe cycle.
  task automatic send_byte(input logic [7:0] code);
    @(negedge clk);
    ifa.scan_valid = 1'b1; ifa.scan_code = code;
    ifb.scan_valid = 1'b1; ifb.scan_code = code;
    @(negedge clk);
    ifa.scan_valid = 1'b0;
    ifb.scan_valid = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    ifa.letter_ready = r;
    ifb.letter_ready = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    ifa.scan_valid = 1'b0; ifa.scan_code = 8'h00;
    ifb.scan_valid = 1'b0; ifb.scan_code = 8'h00;
    set_ready(1'b1);
    rst_l = 1'b0;

    // Reset holds outputs at zero even with bytes arriving.
    idle(1);
    ifa.scan_valid = 1'b1; ifa.scan_code = 8'h1C;
    ifb.scan_valid = 1'b1; ifb.scan_code = 8'h1C;
    idle(2);
    chk("rst_valid", ifa.letter_valid, 1'b0);
    chk("rst_letter", ifa.letter, 5'd0);
    chk("rst_ovf", ifa.overflow, 1'b0);
    ifa.scan_valid = 1'b0;
    ifb.scan_valid = 1'b0;
    idle(1);
    rst_l = 1'b1;
    idle(2);
    chk("post_rst_valid", ifa.letter_valid, 1'b0);

    // 1C, F0, 1C: single A pulse one cycle after the make.
    base_a = acc_a;
    send_byte(8'h1C);
    chk("a_valid", ifa.letter_valid, 1'b1);
    chk("a_letter", ifa.letter, 5'd0);
    idle(1);
    chk("a_drop", ifa.letter_valid, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk("a_brk_noemit", ifa.letter_valid, 1'b0);
    idle(1);
    chk("a_count", acc_a - base_a, 1);
    // Held was cleared, so A makes again.
    send_byte(8'h1C);
    chk("a_again", ifa.letter_valid, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h1C);

    // A few other map entries plus a non-letter code.
    send_byte(8'h32); chk("map_B", ifa.letter, 5'd1);
    send_byte(8'h4D); chk("map_P", ifa.letter, 5'd15);
    send_byte(8'h2C); chk("map_T", ifa.letter, 5'd19);
    idle(1);
    send_byte(8'hAA); chk("map_AA_none", ifa.letter_valid, 1'b0);
    send_byte(8'hF0); send_byte(8'h2C);

    // Typematic repeat suppression vs. pass-through.
    idle(1);
    base_a = acc_a; base_b = acc_b;
    send_byte(8'h15); send_byte(8'h15); send_byte(8'h15);
    send_byte(8'hF0); send_byte(8'h15); send_byte(8'h15);
    idle(2);
    chk("rep_sup_cnt", acc_a - base_a, 2);
    chk("rep_all_cnt", acc_b - base_b, 4);
    chk("rep_letter", ifa.letter, 5'd16);
    send_byte(8'hF0); send_byte(8'h15);

    // Extended sequences are discarded entirely.
    idle(1);
    base_a = acc_a;
    send_byte(8'hE0); send_byte(8'h1C);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h76);
    idle(2);
    chk("ext_none", acc_a - base_a, 0);
    // Back in IDLE with nothing held: A emits.
    send_byte(8'h1C);
    chk("ext_then_A", ifa.letter_valid, 1'b1);
    chk("ext_then_A_l", ifa.letter, 5'd0);
    send_byte(8'hF0); send_byte(8'h1C);
    idle(1);

    // Backpressure: Z held in buffer, B dropped, overflow sticky.
    set_ready(1'b0);
    send_byte(8'h1A);
    chk("bp_valid", ifa.letter_valid, 1'b1);
    chk("bp_letter", ifa.letter, 5'd25);
    send_byte(8'hF0); send_byte(8'h1A); send_byte(8'h32);
    idle(1);
    chk("bp_hold_l", ifa.letter, 5'd25);
    chk("bp_hold_v", ifa.letter_valid, 1'b1);
    chk("bp_ovf", ifa.overflow, 1'b1);
    set_ready(1'b1);
    idle(1);
    chk("bp_consumed", ifa.letter_valid, 1'b0);
    chk("bp_ovf_sticky", ifa.overflow, 1'b1);
    send_byte(8'hF0); send_byte(8'h32);

    // F0 then reset: prefix discarded, 1C after release is a make.
    send_byte(8'hF0);
    rst_l = 1'b0;
    #1;
    chk("rst_async_ovf", ifa.overflow, 1'b0);
    idle(2);
    chk("rst2_valid", ifa.letter_valid, 1'b0);
    chk("rst2_letter", ifa.letter, 5'd0);
    rst_l = 1'b1;
    send_byte(8'h1C);
    chk("rst2_A_valid", ifa.letter_valid, 1'b1);
    chk("rst2_A_letter", ifa.letter, 5'd0);
    idle(1);

    // Buffer full with Y; refill with X on the consuming cycle.
    set_ready(1'b0);
    send_byte(8'h35);
    chk("swap_Y", ifa.letter, 5'd24);
    set_ready(1'b1);
    ifa.scan_valid = 1'b1; ifa.scan_code = 8'h22;
    ifb.scan_valid = 1'b1; ifb.scan_code = 8'h22;
    @(negedge clk);
    ifa.scan_valid = 1'b0;
    ifb.scan_valid = 1'b0;
    chk("swap_X_l", ifa.letter, 5'd23);
    chk("swap_X_v", ifa.letter_valid, 1'b1);
    chk("swap_ovf", ifa.overflow, 1'b0);
    idle(1);
    chk("swap_drain", ifa.letter_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_scan_decode.md
PS2_SCAN_DECODE -- requirements
Module: ps2_scan_decode

Interface
REQ-001 Parameter: SUPPRESS_REPEAT, default 1, 1 = typematic repeats of a held key are dropped; 0 = every make emits.
REQ-002 clk  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-003 rst_l  input  1  asynchronous, active-low reset.
REQ-004 scan_valid  input  1  one-cycle strobe: scan_code holds a complete PS/2 set-2 byte from the upstream receiver.
REQ-005 scan_code  input  8  received byte; sampled only when scan_valid=1.
REQ-006 letter_ready  input  1  downstream (rotor stage) accepts letter this cycle when letter_valid=1.
REQ-007 letter_valid  output  1  letter holds a decoded keypress.
REQ-008 letter  output  5  letter index 0 (A) .. 25 (Z).
REQ-009 overflow  output  1  sticky: a decoded letter was dropped because the output buffer was full.

Function
REQ-010 Prefix FSM states SHALL be IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen); state advances only on cycles with scan_valid=1.
REQ-011 IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code, processed per REQ-013, stay IDLE.
REQ-012 BRK: any byte is a break code, processed per REQ-015, -> IDLE; EXT: F0 -> EXT_BRK, else -> IDLE with byte discarded; EXT_BRK: any byte -> IDLE, discarded.
REQ-013 Letter map (make code -> index): 1C A0, 32 B1, 21 C2, 23 D3, 24 E4, 2B F5, 34 G6, 33 H7, 43 I8, 3B J9, 42 K10, 4B L11, 3A M12, 31 N13, 44 O14, 4D P15, 15 Q16, 2D R17, 1B S18, 2C T19, 3C U20, 2A V21, 1D W22, 22 X23, 35 Y24, 1A Z25; all other make codes (incl. AA, FA, FE) SHALL be ignored with no state change besides the FSM.
REQ-014 Letter make: if SUPPRESS_REPEAT=1 and held=1 and code equals held_code, drop; otherwise set held=1, held_code=code, and emit the index.
REQ-015 Break: if code equals held_code, clear held; otherwise no effect; break never emits.
REQ-016 Emit latency: letter_valid SHALL rise on the cycle after the scan_valid cycle carrying the make byte.
REQ-017 Output buffer is a single register; letter and letter_valid SHALL stay stable while letter_valid=1 and letter_ready=0.
REQ-018 letter_valid=1 and letter_ready=1 on a cycle: entry consumed; letter_valid falls next cycle unless an emit occurs that same cycle.
REQ-019 Emit while buffer full and letter_ready=0: new letter dropped, buffer unchanged, overflow set to 1 next cycle.
REQ-020 Emit in the same cycle as letter_ready=1 with buffer full: new letter loaded, letter_valid stays 1, no overflow.
REQ-021 overflow SHALL remain 1 until reset.
REQ-022 scan_valid=1 while letter_ready=0 SHALL still be decoded (FSM and held state always advance); only the emit path is subject to REQ-019.

Reset
REQ-023 rst_l=0 SHALL asynchronously force: FSM=IDLE, held=0, held_code=00, letter_valid=0, letter=0, overflow=0.
REQ-024 Reset mid-sequence (after F0 or E0) SHALL discard the prefix; first byte after release is treated from IDLE.
REQ-025 Outputs SHALL hold reset values while rst_l=0 regardless of scan_valid.

Verification
REQ-026 Bytes 1C, F0, 1C with letter_ready=1 -> exactly one letter_valid pulse, letter=0, one cycle after the 1C strobe; held cleared.
REQ-027 SUPPRESS_REPEAT=1: bytes 15, 15, 15, F0, 15, 15 -> two emits of 16; SUPPRESS_REPEAT=0: same bytes -> four emits of 16.
REQ-028 Bytes E0, 1C, E0, F0, 1C, 76 -> no emit, FSM ends IDLE, held=0.
REQ-029 letter_ready=0; bytes 1A, F0, 1A, 32 -> letter=25 held stable, 32 dropped, overflow=1; then letter_ready=1 -> 25 consumed, letter_valid=0 next cycle, overflow stays 1.
REQ-030 Buffer holds 24 (35); on cycle with letter_ready=1 make 22 arrives -> letter=23 next cycle, letter_valid=1, overflow=0.
REQ-031 Byte F0, then rst_l pulsed low for 2 cycles, then 1C -> letter=0 emitted; all outputs 0 during reset.
